// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit logic unit front end.
//   ld_state_t : operand loader FSM encoding (2'b11 unused, recovers to WAIT_A)
//   OPND_W     : default operand width
package alu_pkg;

  localparam int OPND_W = 4;

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } ld_state_t;

endpackage

// File: rtl/operand_loader_btn_pulse.sv
// btn_pulse: turns the asynchronous load button into a single-cycle load_pulse.
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   btn        in  asynchronous push button, active-high
//   load_pulse out one-cycle pulse per accepted press
// Build option: DEBOUNCE_EN adds a stable-high qualification of DEB_CYCLES cycles.
module btn_pulse #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic load_pulse
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYCLES);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Down-counter reloads while the button is low and parks at zero once the
  // press is qualified, so a long hold fires exactly once.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!sync2_q) begin
      cnt_d = DEB_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d   = cnt_q - 1'b1;
      pulse_d = (cnt_q == DW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= DEB_LOAD;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign load_pulse = pulse_q;
`else
  logic sync3_q;

  always_ff @(posedge clk) begin
    if (rst) sync3_q <= 1'b0;
    else     sync3_q <= sync2_q;
  end

  assign load_pulse = sync2_q & ~sync3_q;
`endif

endmodule

// File: rtl/operand_loader.sv
// operand_loader: captures operand A then operand B from a shared switch bus
// on successive button presses and offers the pair with a valid/ready handshake.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   sw                 operand value from switches
//   btn_load           asynchronous load button
//   clr                synchronous soft clear (keeps pair_count)
//   op_ready           consumer accepts the pair
//   A_num, B_num       registered operands
//   op_valid           pair complete and stable
//   state_o            FSM state (alu_pkg::ld_state_t encoding)
//   pair_count         handshakes completed, wraps modulo 2**CNT_W
// Build option: DEBOUNCE_EN (handled inside btn_pulse).
//
// state  | meaning
// WAIT_A | waiting for the press that loads operand A
// WAIT_B | A held, waiting for the press that loads operand B
// READY  | pair presented, op_valid high until op_ready
module operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH      = OPND_W,
  parameter int CNT_W      = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             clr,
  input  logic             op_ready,
  output logic [WIDTH-1:0] A_num,
  output logic [WIDTH-1:0] B_num,
  output logic             op_valid,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] pair_count
);

  logic load_pulse;

  btn_pulse #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_pulse (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn_load),
    .load_pulse (load_pulse)
  );

  ld_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = WAIT_A;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        WAIT_A: if (load_pulse) begin
          state_d = WAIT_B;
          a_d     = sw;
        end
        WAIT_B: if (load_pulse) begin
          state_d = READY;
          b_d     = sw;
        end
        // Loads arriving here are dropped, not queued.
        READY: if (op_ready) begin
          state_d = WAIT_A;
          cnt_d   = cnt_q + 1'b1;
        end
        default: state_d = WAIT_A;
      endcase
    end
    valid_d = (state_d == READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign A_num      = a_q;
  assign B_num      = b_q;
  assign op_valid   = valid_q;
  assign state_o    = state_q;
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;
  import alu_pkg::*;

  localparam int DEB = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int SETTLE = LAT + 2;

  logic       clk = 1'b0;
  logic       rst, btn_load, clr, op_ready;
  logic [3:0] sw, A_num, B_num, pair_count;
  logic       op_valid;
  logic [1:0] state_o;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_cnt = '0;
  logic [7:0] sb[$];

  operand_loader #(.WIDTH(4), .CNT_W(4), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .clr(clr),
    .op_ready(op_ready), .A_num(A_num), .B_num(B_num), .op_valid(op_valid),
    .state_o(state_o), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  task automatic press(input logic [3:0] val, input int hold);
    sw = val;
    btn_load = 1'b1;
    repeat (hold) @(negedge clk);
    btn_load = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic load_pair(input logic [3:0] a, input logic [3:0] b);
    press(a, 5);
    press(b, 5);
    sb.push_back({a, b});
  endtask

  task automatic handshake();
    int waited = 0;
    logic [7:0] exp_pair;
    while (op_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (op_valid !== 1'b1) begin
      n_err++;
      $display("FAIL handshake_wait: op_valid=%b required 1", op_valid);
    end else begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: pair A=%0d B=%0d presented, none expected", A_num, B_num);
      end else begin
        exp_pair = sb.pop_front();
        if ({A_num, B_num} !== exp_pair)
          begin n_err++; $display("FAIL pair: A=%0d B=%0d required A=%0d B=%0d", A_num, B_num, exp_pair[7:4], exp_pair[3:0]); end
      end
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      exp_cnt++;
      n_vec++;
      if (op_valid !== 1'b0 || pair_count !== exp_cnt || state_o !== WAIT_A)
        begin n_err++; $display("FAIL handshake_done: valid=%b cnt=%0d st=%0d required 0 %0d 0", op_valid, pair_count, state_o, exp_cnt); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (A_num !== 4'd0 || B_num !== 4'd0 || op_valid !== 1'b0 || pair_count !== 4'd0 || state_o !== WAIT_A)
      begin n_err++; $display("FAIL reset: A=%0d B=%0d valid=%b cnt=%0d st=%0d required all 0", A_num, B_num, op_valid, pair_count, state_o); end
    exp_cnt = '0;
  endtask

  task automatic test_load_pair();
    sw = 4'b1000;
    btn_load = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    n_vec++;
    if (A_num !== 4'd0 || state_o !== WAIT_A)
      begin n_err++; $display("FAIL latency_early: A=%0d st=%0d required 0 0", A_num, state_o); end
    @(negedge clk);
    n_vec++;
    if (A_num !== 4'd8 || state_o !== WAIT_B)
      begin n_err++; $display("FAIL latency_load: A=%0d st=%0d required 8 1", A_num, state_o); end
    btn_load = 1'b0;
    repeat (SETTLE) @(negedge clk);
    press(4'b1010, 5);
    sb.push_back({4'd8, 4'd10});
    n_vec++;
    if (A_num !== 4'd8 || B_num !== 4'd10 || op_valid !== 1'b1 || state_o !== READY)
      begin n_err++; $display("FAIL load_pair: A=%0d B=%0d valid=%b st=%0d required 8 10 1 2", A_num, B_num, op_valid, state_o); end
    handshake();
    n_vec++;
    if (A_num !== 4'd8 || B_num !== 4'd10)
      begin n_err++; $display("FAIL hold_after_hs: A=%0d B=%0d required 8 10", A_num, B_num); end
  endtask

  task automatic test_hold_button();
    press(4'b1110, 20);
    n_vec++;
    if (A_num !== 4'd14 || B_num !== 4'd10 || state_o !== WAIT_B)
      begin n_err++; $display("FAIL long_hold: A=%0d B=%0d st=%0d required 14 10 1", A_num, B_num, state_o); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_vec++;
    if (A_num !== 4'd0 || B_num !== 4'd0 || state_o !== WAIT_A || pair_count !== exp_cnt)
      begin n_err++; $display("FAIL clr_full: A=%0d B=%0d st=%0d cnt=%0d required 0 0 0 %0d", A_num, B_num, state_o, pair_count, exp_cnt); end
  endtask

  task automatic test_load_in_ready();
    load_pair(4'b1011, 4'b1100);
    press(4'b0111, 5);
    n_vec++;
    if (A_num !== 4'd11 || B_num !== 4'd12 || op_valid !== 1'b1 || state_o !== READY)
      begin n_err++; $display("FAIL load_in_ready: A=%0d B=%0d valid=%b st=%0d required 11 12 1 2", A_num, B_num, op_valid, state_o); end
    op_ready = 1'b1;
    sw = 4'b0001;
    n_vec++;
    if (state_o !== READY)
      begin n_err++; $display("FAIL ready_ignores_outside: st=%0d required 2", state_o); end
    op_ready = 1'b0;
    handshake();
    repeat (3) @(negedge clk);
    n_vec++;
    if (state_o !== WAIT_A || A_num !== 4'd11)
      begin n_err++; $display("FAIL not_queued: st=%0d A=%0d required 0 11", state_o, A_num); end
  endtask

  task automatic test_ready_outside();
    op_ready = 1'b1;
    repeat (3) @(negedge clk);
    op_ready = 1'b0;
    n_vec++;
    if (pair_count !== exp_cnt || state_o !== WAIT_A)
      begin n_err++; $display("FAIL ready_in_wait: cnt=%0d st=%0d required %0d 0", pair_count, state_o, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    load_pair(4'd5, 4'd6);
    sw = 4'd9;
    btn_load = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    void'(sb.pop_front());
    exp_cnt++;
    n_vec++;
    if (state_o !== WAIT_A || pair_count !== exp_cnt || A_num !== 4'd5 || op_valid !== 1'b0)
      begin n_err++; $display("FAIL ready_and_load: st=%0d cnt=%0d A=%0d valid=%b required 0 %0d 5 0", state_o, pair_count, A_num, op_valid, exp_cnt); end
    btn_load = 1'b0;
    repeat (SETTLE) @(negedge clk);
    n_vec++;
    if (state_o !== WAIT_A || A_num !== 4'd5)
      begin n_err++; $display("FAIL load_dropped: st=%0d A=%0d required 0 5", state_o, A_num); end
  endtask

  task automatic test_clr();
    press(4'b0111, 5);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_vec++;
    if (A_num !== 4'd0 || state_o !== WAIT_A || pair_count !== exp_cnt)
      begin n_err++; $display("FAIL clr_wait_b: A=%0d st=%0d cnt=%0d required 0 0 %0d", A_num, state_o, pair_count, exp_cnt); end
    load_pair(4'd1, 4'd2);
    clr = 1'b1;
    op_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    op_ready = 1'b0;
    void'(sb.pop_back());
    n_vec++;
    if (pair_count !== exp_cnt || state_o !== WAIT_A || op_valid !== 1'b0 || A_num !== 4'd0 || B_num !== 4'd0)
      begin n_err++; $display("FAIL clr_beats_ready: cnt=%0d st=%0d valid=%b A=%0d B=%0d required %0d 0 0 0 0", pair_count, state_o, op_valid, A_num, B_num, exp_cnt); end
  endtask

  task automatic test_wrap();
    logic [3:0] a, b;
    for (int i = 0; i < 16 && (i == 0 || exp_cnt != 4'd0); i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      load_pair(a, b);
      handshake();
    end
    n_vec++;
    if (pair_count !== 4'd0)
      begin n_err++; $display("FAIL wrap: cnt=%0d required 0", pair_count); end
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_debounce();
    logic [3:0] a_before;
    a_before = A_num;
    press(4'd3, 3);
    n_vec++;
    if (A_num !== a_before || state_o !== WAIT_A)
      begin n_err++; $display("FAIL short_press: A=%0d st=%0d required %0d 0", A_num, state_o, a_before); end
    press(4'd9, 5);
    n_vec++;
    if (A_num !== 4'd9 || state_o !== WAIT_B)
      begin n_err++; $display("FAIL long_press: A=%0d st=%0d required 9 1", A_num, state_o); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    press(4'd13, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    n_vec++;
    if (A_num !== 4'd0 || state_o !== WAIT_A || pair_count !== 4'd0)
      begin n_err++; $display("FAIL rst_mid: A=%0d st=%0d cnt=%0d required 0 0 0", A_num, state_o, pair_count); end
  endtask

  initial begin
    rst = 1'b1; btn_load = 1'b0; clr = 1'b0; op_ready = 1'b0; sw = '0;
    @(negedge clk);
    test_reset();
    test_load_pair();
    test_hold_button();
    test_load_in_ready();
    test_ready_outside();
    test_back_to_back();
    test_clr();
    test_wrap();
`ifdef DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
